// File: rtl/fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer
//
// Control FSM for the three-layer fully-connected engine. It owns the
// ping-pong input-bank handshake with the RAM writer, walks layers 1 -> 2 -> 3
// with fin/fout counters, and paces weight-FIFO pops, data-RAM reads,
// accumulator enable/clear and output-buffer writes. Once layer 3 has been
// stored it raises result_valid and holds it until the host acknowledges.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   writer_done         writer has filled the idle input bank (level)
//   writer_en           one-cycle pulse: bank swap granted, writer may refill
//   buf_sel             input bank read by layer 1
//   weight_fifo_empty   weight FIFO has no word
//   weight_fifo_rden    pop one AF-wide weight word (data valid next cycle)
//   data_rd_addr        current fin, presented with weight_fifo_rden
//   layer_idx           active layer 0/1/2, 0 when idle
//   acc_en              accumulate the pair read in the previous cycle
//   acc_clr             clear accumulators (with out_wr_en, after capture)
//   out_wr_en           store quantised accumulator
//   out_wr_addr         fout / AF
//   out_lane            fout % AF
//   busy                computation in progress
//   result_valid        layer-3 results readable
//   result_ack          one-cycle pulse: host finished reading
// ---------------------------------------------------------------------------
module fc_layer_sequencer #(
    parameter int unsigned AF         = 3,
    parameter int unsigned FIN1       = 34,
    parameter int unsigned FIN2       = 5,
    parameter int unsigned FIN3       = 5,
    parameter int unsigned FOUT1      = 15,
    parameter int unsigned FOUT2      = 15,
    parameter int unsigned FOUT3      = 12,
    parameter int unsigned ADDR_WIDTH = 32,
    // Derived; not meant to be overridden.
    parameter int unsigned LANE_W     = (AF > 1) ? $clog2(AF) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  writer_done,
    output logic                  writer_en,
    output logic                  buf_sel,
    input  logic                  weight_fifo_empty,
    output logic                  weight_fifo_rden,
    output logic [ADDR_WIDTH-1:0] data_rd_addr,
    output logic [1:0]            layer_idx,
    output logic                  acc_en,
    output logic                  acc_clr,
    output logic                  out_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [LANE_W-1:0]     out_lane,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ack
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_DIM = max2(max2(max2(FIN1, FIN2), max2(FIN3, FOUT1)),
                                           max2(FOUT2, FOUT3));
    // One spare bit so fin can step one past its last value without wrapping.
    localparam int unsigned CNT_W   = $clog2(MAX_DIM) + 1;

    localparam logic [CNT_W-1:0]  FIN1_LAST  = CNT_W'(FIN1 - 1);
    localparam logic [CNT_W-1:0]  FIN2_LAST  = CNT_W'(FIN2 - 1);
    localparam logic [CNT_W-1:0]  FIN3_LAST  = CNT_W'(FIN3 - 1);
    localparam logic [CNT_W-1:0]  FOUT1_LAST = CNT_W'(FOUT1 - 1);
    localparam logic [CNT_W-1:0]  FOUT2_LAST = CNT_W'(FOUT2 - 1);
    localparam logic [CNT_W-1:0]  FOUT3_LAST = CNT_W'(FOUT3 - 1);
    localparam logic [LANE_W-1:0] AF_LAST    = LANE_W'(AF - 1);

    localparam logic [2:0] StWait   = 3'd0;
    localparam logic [2:0] StMac    = 3'd1;
    localparam logic [2:0] StDrain  = 3'd2;
    localparam logic [2:0] StStore  = 3'd3;
    localparam logic [2:0] StResult = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              buf_sel_q, buf_sel_d;
    logic [CNT_W-1:0]  fin_q, fin_d;
    logic [CNT_W-1:0]  fout_q, fout_d;
    // fout split into word/lane so no divider is needed for the write address.
    logic [CNT_W-1:0]  word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [1:0]        layer_q, layer_d;
    logic              rden_q;

    logic              swap;
    logic              rden;
    logic [CNT_W-1:0]  fin_last;
    logic [CNT_W-1:0]  fout_last;

    // Per-layer loop bounds.
    always_comb begin
        fin_last  = FIN1_LAST;
        fout_last = FOUT1_LAST;
        case (layer_q)
            2'd1: begin
                fin_last  = FIN2_LAST;
                fout_last = FOUT2_LAST;
            end
            2'd2: begin
                fin_last  = FIN3_LAST;
                fout_last = FOUT3_LAST;
            end
            default: begin
                fin_last  = FIN1_LAST;
                fout_last = FOUT1_LAST;
            end
        endcase
    end

    assign swap = (state_q == StWait) && writer_done;
    // A pop happens in any MAC cycle the FIFO has a word; otherwise stall.
    assign rden = (state_q == StMac) && !weight_fifo_empty;

    always_comb begin
        state_d   = state_q;
        buf_sel_d = buf_sel_q;
        fin_d     = fin_q;
        fout_d    = fout_q;
        word_d    = word_q;
        lane_d    = lane_q;
        layer_d   = layer_q;

        case (state_q)
            StWait: begin
                if (writer_done) begin
                    buf_sel_d = ~buf_sel_q;
                    fin_d     = '0;
                    fout_d    = '0;
                    word_d    = '0;
                    lane_d    = '0;
                    layer_d   = 2'd0;
                    state_d   = StMac;
                end
            end

            StMac: begin
                if (rden) begin
                    fin_d = fin_q + 1'b1;
                    if (fin_q == fin_last) begin
                        state_d = StDrain;
                    end
                end
            end

            // The last pair's data arrives now; accumulate it before storing.
            StDrain: begin
                state_d = StStore;
            end

            StStore: begin
                fin_d = '0;
                if (fout_q != fout_last) begin
                    fout_d = fout_q + 1'b1;
                    if (lane_q == AF_LAST) begin
                        lane_d = '0;
                        word_d = word_q + 1'b1;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                    state_d = StMac;
                end else begin
                    fout_d = '0;
                    word_d = '0;
                    lane_d = '0;
                    if (layer_q != 2'd2) begin
                        layer_d = layer_q + 2'd1;
                        state_d = StMac;
                    end else begin
                        layer_d = 2'd0;
                        state_d = StResult;
                    end
                end
            end

            // writer_done is deliberately not looked at here: a pending swap
            // is only granted after the host has released the results.
            StResult: begin
                if (result_ack) begin
                    state_d = StWait;
                end
            end

            default: begin
                state_d = StWait;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StWait;
            buf_sel_q <= 1'b0;
            fin_q     <= '0;
            fout_q    <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            layer_q   <= 2'd0;
            rden_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_sel_q <= buf_sel_d;
            fin_q     <= fin_d;
            fout_q    <= fout_d;
            word_q    <= word_d;
            lane_q    <= lane_d;
            layer_q   <= layer_d;
            rden_q    <= rden;
        end
    end

    assign writer_en        = swap;
    assign buf_sel          = buf_sel_q;
    assign weight_fifo_rden = rden;
    assign data_rd_addr     = ADDR_WIDTH'(fin_q);
    assign layer_idx        = layer_q;
    // RAM and FIFO both return data one cycle after the pop.
    assign acc_en           = rden_q;
    assign acc_clr          = (state_q == StStore);
    assign out_wr_en        = (state_q == StStore);
    assign out_wr_addr      = ADDR_WIDTH'(word_q);
    assign out_lane         = lane_q;
    assign busy             = (state_q == StMac) || (state_q == StDrain) ||
                              (state_q == StStore);
    assign result_valid     = (state_q == StResult);

    // Zero-sized layers would make the last-index compares wrap.
    dims_nonzero_a: assert property (@(posedge clk)
        (FIN1 != 0) && (FIN2 != 0) && (FIN3 != 0) &&
        (FOUT1 != 0) && (FOUT2 != 0) && (FOUT3 != 0) && (AF != 0));

    acc_wr_exclusive_a: assert property (@(posedge clk) disable iff (!rstn)
        !(acc_en && out_wr_en));

endmodule
